mux_gate_sweeper: RTL

- Sequential stimulus/capture stage that sits directly upstream of one m2x1 mux-as-gate cell.
- For a requested gate opcode, it sweeps all four {a,b} operand pairs and drives the mux data pair and select (select = b).
- It samples the mux output for each pair, assembles a 4-bit truth table and compares it against the golden table for that gate.
- Start/done handshake, so a controller can self-test the mux gate realisations one gate at a time.

---
 rtl/mux_gate_pkg.sv | 31 +++
 rtl/mux_gate_map.sv | 54 +++++
 rtl/mux_gate_sweeper.sv | 187 ++++++++++++++++++
 3 files changed

// File: rtl/mux_gate_pkg.sv
`default_nettype none
// ============================================================================
// Module  : mux_gate_pkg
// Purpose : Shared opcodes, golden truth tables and FSM states for the sweeper.
// Rev     : 1.0
// ============================================================================
package mux_gate_pkg;

    localparam logic [2:0] OP_AND  = 3'd0;
    localparam logic [2:0] OP_OR   = 3'd1;
    localparam logic [2:0] OP_NOR  = 3'd2;
    localparam logic [2:0] OP_NAND = 3'd3;
    localparam logic [2:0] OP_XOR  = 3'd4;
    localparam logic [2:0] OP_XNOR = 3'd5;

    // Bit j holds the gate output for {a,b} = j.
    localparam logic [3:0] GOLD_AND  = 4'b1000;
    localparam logic [3:0] GOLD_OR   = 4'b1110;
    localparam logic [3:0] GOLD_NOR  = 4'b0001;
    localparam logic [3:0] GOLD_NAND = 4'b0111;
    localparam logic [3:0] GOLD_XOR  = 4'b0110;
    localparam logic [3:0] GOLD_XNOR = 4'b1001;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

endpackage
`default_nettype wire

// File: rtl/mux_gate_map.sv
`default_nettype none
// ============================================================================
// Module  : mux_gate_map
// Purpose : Per-gate mux data-input mapping and golden table lookup.
// Rev     : 1.0
// ============================================================================
module mux_gate_map
    import mux_gate_pkg::*;
(
    input  logic [2:0] i_op,
    input  logic       i_a,
    output logic [1:0] o_i,
    output logic [3:0] o_expected,
    output logic       o_illegal
);

    // o_i is {i[1], i[0]}; the mux select carries b, so i[0] is the b=0 leg.
    always_comb begin
        o_i        = 2'b00;
        o_expected = 4'b0000;
        o_illegal  = 1'b0;
        case (i_op)
            OP_AND: begin
                o_i        = {i_a, 1'b0};
                o_expected = GOLD_AND;
            end
            OP_OR: begin
                o_i        = {1'b1, i_a};
                o_expected = GOLD_OR;
            end
            OP_NOR: begin
                o_i        = {1'b0, ~i_a};
                o_expected = GOLD_NOR;
            end
            OP_NAND: begin
                o_i        = {~i_a, 1'b1};
                o_expected = GOLD_NAND;
            end
            OP_XOR: begin
                o_i        = {~i_a, i_a};
                o_expected = GOLD_XOR;
            end
            OP_XNOR: begin
                o_i        = {i_a, ~i_a};
                o_expected = GOLD_XNOR;
            end
            default: begin
                o_illegal  = 1'b1;
            end
        endcase
    end

endmodule
`default_nettype wire

// File: rtl/mux_gate_sweeper.sv
`default_nettype none
// ============================================================================
// Module  : mux_gate_sweeper
// Purpose : Sweeps all {a,b} pairs through an m2x1 gate and checks its table.
// Rev     : 1.0
// ============================================================================
module mux_gate_sweeper
    import mux_gate_pkg::*;
#(
    parameter int HOLD = 1
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       start,
    input  logic [2:0] op,
    output logic       mux_en,
    output logic       mux_s,
    output logic [1:0] mux_i,
    input  logic       mux_y,
    output logic       busy,
    output logic       done,
    output logic [3:0] truth,
    output logic       pass,
    output logic       err_op
);

    localparam logic [3:0] C_RELOAD = 4'(HOLD - 1);

    state_t     r_state;
    logic [2:0] r_op;
    logic [1:0] r_j;
    logic [3:0] r_cnt;
    logic       r_mux_en;
    logic       r_mux_s;
    logic [1:0] r_mux_i;
    logic       r_busy;
    logic       r_done;
    logic [3:0] r_truth;
    logic       r_pass;
    logic       r_err_op;

    state_t     w_state_nxt;
    logic [2:0] w_op_nxt;
    logic [1:0] w_j_nxt;
    logic [3:0] w_cnt_nxt;
    logic       w_mux_en_nxt;
    logic       w_mux_s_nxt;
    logic [1:0] w_mux_i_nxt;
    logic       w_busy_nxt;
    logic       w_done_nxt;
    logic [3:0] w_truth_nxt;
    logic       w_pass_nxt;
    logic       w_err_op_nxt;

    logic [1:0] w_j_inc;
    logic [2:0] w_map_op;
    logic       w_map_a;
    logic [1:0] w_map_i;
    logic [3:0] w_map_expected;
    logic       w_map_illegal;
    logic [3:0] w_sampled;

    // In IDLE the map looks at the incoming op for pair 0; in RUN at the
    // latched op for the pair about to be loaded.
    assign w_j_inc  = r_j + 2'd1;
    assign w_map_op = (r_state == ST_IDLE) ? op : r_op;
    assign w_map_a  = (r_state == ST_IDLE) ? 1'b0 : w_j_inc[1];

    mux_gate_map u_map (
        .i_op       (w_map_op),
        .i_a        (w_map_a),
        .o_i        (w_map_i),
        .o_expected (w_map_expected),
        .o_illegal  (w_map_illegal)
    );

    always_comb begin
        w_sampled      = r_truth;
        w_sampled[r_j] = mux_y;
    end

    always_comb begin
        w_state_nxt  = r_state;
        w_op_nxt     = r_op;
        w_j_nxt      = r_j;
        w_cnt_nxt    = r_cnt;
        w_mux_en_nxt = r_mux_en;
        w_mux_s_nxt  = r_mux_s;
        w_mux_i_nxt  = r_mux_i;
        w_busy_nxt   = r_busy;
        w_done_nxt   = 1'b0;
        w_truth_nxt  = r_truth;
        w_pass_nxt   = r_pass;
        w_err_op_nxt = r_err_op;
        case (r_state)
            ST_IDLE: begin
                if (start) begin
                    w_op_nxt    = op;
                    w_truth_nxt = 4'b0000;
                    w_pass_nxt  = 1'b0;
                    w_j_nxt     = 2'd0;
                    if (w_map_illegal) begin
                        w_err_op_nxt = 1'b1;
                        w_done_nxt   = 1'b1;
                        w_state_nxt  = ST_DONE;
                    end else begin
                        w_err_op_nxt = 1'b0;
                        w_busy_nxt   = 1'b1;
                        w_mux_en_nxt = 1'b1;
                        w_mux_s_nxt  = 1'b0;
                        w_mux_i_nxt  = w_map_i;
                        w_cnt_nxt    = C_RELOAD;
                        w_state_nxt  = ST_RUN;
                    end
                end
            end
            ST_RUN: begin
                if (r_cnt != 4'd0) begin
                    w_cnt_nxt = r_cnt - 4'd1;
                end else begin
                    w_truth_nxt = w_sampled;
                    if (r_j != 2'd3) begin
                        w_j_nxt     = w_j_inc;
                        w_mux_s_nxt = w_j_inc[0];
                        w_mux_i_nxt = w_map_i;
                        w_cnt_nxt   = C_RELOAD;
                    end else begin
                        w_mux_en_nxt = 1'b0;
                        w_mux_s_nxt  = 1'b0;
                        w_mux_i_nxt  = 2'b00;
                        w_busy_nxt   = 1'b0;
                        w_pass_nxt   = (w_sampled == w_map_expected);
                        w_done_nxt   = 1'b1;
                        w_state_nxt  = ST_DONE;
                    end
                end
            end
            ST_DONE: begin
                w_state_nxt = ST_IDLE;
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state  <= ST_IDLE;
            r_op     <= 3'd0;
            r_j      <= 2'd0;
            r_cnt    <= 4'd0;
            r_mux_en <= 1'b0;
            r_mux_s  <= 1'b0;
            r_mux_i  <= 2'b00;
            r_busy   <= 1'b0;
            r_done   <= 1'b0;
            r_truth  <= 4'b0000;
            r_pass   <= 1'b0;
            r_err_op <= 1'b0;
        end else begin
            r_state  <= w_state_nxt;
            r_op     <= w_op_nxt;
            r_j      <= w_j_nxt;
            r_cnt    <= w_cnt_nxt;
            r_mux_en <= w_mux_en_nxt;
            r_mux_s  <= w_mux_s_nxt;
            r_mux_i  <= w_mux_i_nxt;
            r_busy   <= w_busy_nxt;
            r_done   <= w_done_nxt;
            r_truth  <= w_truth_nxt;
            r_pass   <= w_pass_nxt;
            r_err_op <= w_err_op_nxt;
        end
    end

    assign mux_en = r_mux_en;
    assign mux_s  = r_mux_s;
    assign mux_i  = r_mux_i;
    assign busy   = r_busy;
    assign done   = r_done;
    assign truth  = r_truth;
    assign pass   = r_pass;
    assign err_op = r_err_op;

endmodule
`default_nettype wire
